// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed common-anode seven-segment scanner
// with frame-boundary double buffering of the display word.
module sevenseg_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     blank,
   input  logic [DIGITS-1:0]     dp_in,
   output logic                  a,
   output logic                  b,
   output logic                  c,
   output logic                  d,
   output logic                  e,
   output logic                  f,
   output logic                  g,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  update_pending,
   output logic                  frame_done
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(DIGITS);
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [4*DIGITS-1:0]    sh_val, act_val;
   logic [DIGITS-1:0]      sh_blank, sh_dp, act_blank, act_dp;
   logic                   slot_end, frame_end, lit_on;
   logic [3:0]             nib;
   logic [6:0]             seg;
   assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
   assign frame_end = slot_end && idx == IW'(DIGITS - 1);
   assign lit_on    = cnt >= CW'(BLANK_CYCLES) && !act_blank[idx];
   assign nib       = act_val[{idx, 2'b00} +: 4];
   // active-low {a,b,c,d,e,f,g}
   always_comb begin
      case (nib)
         4'h0: seg = 7'h01;
         4'h1: seg = 7'h4F;
         4'h2: seg = 7'h12;
         4'h3: seg = 7'h06;
         4'h4: seg = 7'h4C;
         4'h5: seg = 7'h24;
         4'h6: seg = 7'h20;
         4'h7: seg = 7'h0F;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h04;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h60;
         4'hC: seg = 7'h31;
         4'hD: seg = 7'h42;
         4'hE: seg = 7'h30;
         default: seg = 7'h38;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         idx            <= '0;
         sh_val         <= '0;
         sh_blank       <= '0;
         sh_dp          <= '0;
         act_val        <= '0;
         act_blank      <= '1;
         act_dp         <= '0;
         update_pending <= 1'b0;
         frame_done     <= 1'b0;
         {a, b, c, d, e, f, g} <= 7'h7F;
         dp             <= 1'b1;
         an             <= '1;
      end else begin
         cnt        <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
         frame_done <= frame_end;
         // a load coinciding with the frame end bypasses the shadow entirely
         if (frame_end) begin
            update_pending <= 1'b0;
            if (load) {act_val, act_blank, act_dp} <= {value, blank, dp_in};
            else if (update_pending) {act_val, act_blank, act_dp} <= {sh_val, sh_blank, sh_dp};
         end else if (load) begin
            {sh_val, sh_blank, sh_dp} <= {value, blank, dp_in};
            update_pending <= 1'b1;
         end
         an  <= lit_on ? ~(DIGITS'(1) << idx) : '1;
         {a, b, c, d, e, f, g} <= lit_on ? seg : 7'h7F;
         dp  <= lit_on ? ~act_dp[idx] : 1'b1;
      end
   end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed bench for the scan controller with
// DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frames).
module tb_sevenseg_scan_ctrl;
   localparam int BL = 2;
   logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  blank = '0, dp_in = '0;
   logic        a, b, c, d, e, f, g, dp, update_pending, frame_done;
   logic [3:0]  an;
   logic [6:0]  seg;
   int          n_checks = 0, n_fail = 0, cyc = 0;
   assign seg = {a, b, c, d, e, f, g};
   always #5 clk = ~clk;
   sevenseg_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(BL)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .blank(blank), .dp_in(dp_in),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
      .update_pending(update_pending), .frame_done(frame_done)
   );
   // lit segments, active-high {a..g}, written straight from the digit shapes
   function automatic logic [6:0] lit(input logic [3:0] h);
      case (h)
         4'h0: lit = 7'b1111110;
         4'h1: lit = 7'b0110000;
         4'h2: lit = 7'b1101101;
         4'h3: lit = 7'b1111001;
         4'h4: lit = 7'b0110011;
         4'h5: lit = 7'b1011011;
         4'h6: lit = 7'b1011111;
         4'h7: lit = 7'b1110000;
         4'h8: lit = 7'b1111111;
         4'h9: lit = 7'b1111011;
         4'hA: lit = 7'b1110111;
         4'hB: lit = 7'b0011111;
         4'hC: lit = 7'b1001110;
         4'hD: lit = 7'b0111101;
         4'hE: lit = 7'b1001111;
         default: lit = 7'b1000111;
      endcase
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask
   // outputs after edge n reflect cnt=(n-1)%8, idx=((n-1)/8)%4 counted from reset release
   task automatic run_check(input int n, input logic [15:0] v, input logic [3:0] bl, input logic [3:0] dpi);
      for (int j = 0; j < n; j++) begin
         int pos, ci, ii;
         logic on;
         logic [3:0] ean;
         logic [6:0] eseg;
         logic edp, efd;
         tick;
         pos  = (cyc - 1) % 32;
         ci   = pos % 8;
         ii   = pos / 8;
         on   = ci >= BL && !bl[ii];
         ean  = on ? ~(4'b0001 << ii) : 4'hF;
         eseg = on ? ~lit(v[4*ii +: 4]) : 7'h7F;
         edp  = on ? ~dpi[ii] : 1'b1;
         efd  = (cyc % 32) == 0;
         chk($sformatf("scan@%0d{an,seg,dp,fd}", cyc), {19'd0, an, seg, dp, frame_done}, {19'd0, ean, eseg, edp, efd});
      end
   endtask
   initial begin
      repeat (3) tick;
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_pend", update_pending, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
      rst = 1'b0;
      cyc = 0;
      run_check(64, 16'h0, 4'hF, 4'h0);
      chk("dark_pend", update_pending, 1'b0);
      run_check(6, 16'h0, 4'hF, 4'h0);
      load = 1'b1; value = 16'h1234; blank = 4'b0000; dp_in = 4'b0010;
      run_check(1, 16'h0, 4'hF, 4'h0);
      load = 1'b0;
      chk("basic_pend_rise", update_pending, 1'b1);
      run_check(24, 16'h0, 4'hF, 4'h0);
      chk("basic_pend_hold", update_pending, 1'b1);
      run_check(1, 16'h0, 4'hF, 4'h0);
      chk("basic_pend_fall", update_pending, 1'b0);
      tick; tick;
      chk("slot0_gap_an", an, 4'hF);
      tick;
      chk("slot0_an", an, 4'b1110);
      chk("slot0_seg4", seg, 7'b1001100);
      chk("slot0_dp", dp, 1'b1);
      repeat (5) tick;
      chk("slot0_last_an", an, 4'b1110);
      tick;
      chk("slot1_gap_an", an, 4'hF);
      chk("slot1_gap_seg", seg, 7'h7F);
      tick; tick;
      chk("slot1_an", an, 4'b1101);
      chk("slot1_seg3", seg, 7'b0000110);
      chk("slot1_dp", dp, 1'b0);
      run_check(21, 16'h1234, 4'h0, 4'b0010);
      run_check(32, 16'h1234, 4'h0, 4'b0010);
      run_check(5, 16'h1234, 4'h0, 4'b0010);
      load = 1'b1; value = 16'hAAAA; blank = 4'h0; dp_in = 4'h0;
      run_check(1, 16'h1234, 4'h0, 4'b0010);
      load = 1'b0;
      chk("dbuf_pend1", update_pending, 1'b1);
      run_check(1, 16'h1234, 4'h0, 4'b0010);
      load = 1'b1; value = 16'h0F0F;
      run_check(1, 16'h1234, 4'h0, 4'b0010);
      load = 1'b0;
      chk("dbuf_pend2", update_pending, 1'b1);
      run_check(23, 16'h1234, 4'h0, 4'b0010);
      chk("dbuf_pend3", update_pending, 1'b1);
      run_check(1, 16'h1234, 4'h0, 4'b0010);
      chk("dbuf_pend_fall", update_pending, 1'b0);
      run_check(32, 16'h0F0F, 4'h0, 4'h0);
      run_check(31, 16'h0F0F, 4'h0, 4'h0);
      load = 1'b1; value = 16'h8888;
      run_check(1, 16'h0F0F, 4'h0, 4'h0);
      load = 1'b0;
      chk("fe_pend_a", update_pending, 1'b0);
      run_check(1, 16'h8888, 4'h0, 4'h0);
      chk("fe_pend_b", update_pending, 1'b0);
      run_check(31, 16'h8888, 4'h0, 4'h0);
      run_check(3, 16'h8888, 4'h0, 4'h0);
      load = 1'b1; value = 16'h5A3C; blank = 4'b0101; dp_in = 4'hF;
      run_check(1, 16'h8888, 4'h0, 4'h0);
      load = 1'b0;
      run_check(28, 16'h8888, 4'h0, 4'h0);
      run_check(32, 16'h5A3C, 4'b0101, 4'hF);
      run_check(2, 16'h5A3C, 4'b0101, 4'hF);
      load = 1'b1; value = 16'h7777; blank = 4'h0; dp_in = 4'h0;
      run_check(1, 16'h5A3C, 4'b0101, 4'hF);
      load = 1'b0;
      chk("mrst_pend_before", update_pending, 1'b1);
      run_check(17, 16'h5A3C, 4'b0101, 4'hF);
      rst = 1'b1;
      tick;
      chk("mrst_an", an, 4'hF);
      chk("mrst_seg", seg, 7'h7F);
      chk("mrst_dp", dp, 1'b1);
      chk("mrst_pend", update_pending, 1'b0);
      chk("mrst_fd", frame_done, 1'b0);
      rst = 1'b0;
      cyc = 0;
      run_check(64, 16'h0, 4'hF, 4'h0);
      chk("mrst_pend_after", update_pending, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a display word and a refresh prescaler, and cycles the active-low digit enables one digit at a time. For the selected digit it drives the hex-decoded, active-low segment lines `a`–`g` and `dp`. New display words are double-buffered and applied only at frame boundaries, so the display never tears. It sits between any value producer (counters, debug registers) and the board's segment/anode pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned (2..8).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (≥ `BLANK_CYCLES`+2).
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `load`, input, 1: one-cycle strobe that captures `value`, `blank`, `dp_in`.
- `value`, input, 4·DIGITS: hex nibble per digit; digit i = `value[4i+3:4i]`.
- `blank`, input, DIGITS: 1 = digit i dark.
- `dp_in`, input, DIGITS: 1 = decimal point of digit i lit.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`, output reg, 1 each: segment drives, active-low.
- `dp`, output reg, 1: decimal point, active-low.
- `an`, output reg, DIGITS: digit enables, active-low, at most one low.
- `update_pending`, output reg, 1: a captured word is waiting for the frame boundary.
- `frame_done`, output reg, 1: one-cycle pulse after the last slot of each frame.

## Operation
- **Reset state:**
  - `a`–`g`=1, `dp`=1, `an`=all 1s.
  - `update_pending`=0, `frame_done`=0.
  - Prescaler `cnt`=0, digit index `idx`=0.
  - Shadow and active registers cleared; active `blank`=all 1s, so the display is dark until the first update.
- **Prescaler:** `cnt` counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps DIGITS-1 → 0.
- **Frame end:** the cycle where `cnt`=REFRESH_DIV-1 and `idx`=DIGITS-1.
- **Load handling:**
  - On `load` (not at frame end), capture `value`/`blank`/`dp_in` into shadow and set `update_pending`.
  - A repeated `load` while pending overwrites the shadow (last write wins).
- **Update at frame end:**
  - If pending, active ← shadow and `update_pending` ← 0.
  - If `load` is asserted in the frame-end cycle itself, the inputs go directly to active and `update_pending` ← 0; any older shadow is discarded.
- **Output generation (all registered from current `idx`, `cnt` and active word):**
  - `an[idx]`=0 only when `cnt` ≥ BLANK_CYCLES and active `blank[idx]`=0. Otherwise all of `an` is 1.
  - Segments decode active nibble `idx`; listed segments are driven 0, the rest 1:
    - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg
    - 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
    - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg
    - C adef; d bcdeg; E adefg; F aefg
  - `dp` = ~active `dp_in[idx]`.
  - Blanked digit or blanking interval: all of `a`–`g`, `dp`, `an` = 1.
- `frame_done` is 1 in the cycle after the frame-end cycle, otherwise 0.
- `rst` asserted mid-slot or mid-update returns every register to the reset state on the next edge. A pending word is lost.

## Timing
- Registered outputs lag internal state by 1 cycle: after `rst` deasserts, `an[0]` first goes low at the edge following `cnt`=BLANK_CYCLES.
- Slot length is exactly REFRESH_DIV cycles; frame length is DIGITS·REFRESH_DIV.
- `an` is low for REFRESH_DIV−BLANK_CYCLES cycles per slot, never two digits low at once, and there are BLANK_CYCLES all-high cycles between consecutive enables.
- Load-to-display latency is 1 to DIGITS·REFRESH_DIV+1 cycles. The new word first appears in slot 0 of the next frame.
- `update_pending` rises the cycle after `load` and falls in the same edge that `frame_done` rises.

## Test plan
Parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- **Reset defaults:** hold `rst` 3 cycles, then release with no load → `an`=1111 and `a`–`g`,`dp`=1 for a full frame; `frame_done` pulses every 32 cycles.
- **Basic scan:** `load` with `value`=16'h1234, `blank`=0000, `dp_in`=0010 → from the next frame:
  - slot0 shows "4": `a`..`g`=1,0,0,1,1,0,0; `an`=1110.
  - slot1 shows "3" with `dp`=0.
  - Each `an` is low 6 cycles with a 2-cycle all-high gap.
- **Double buffering:** load 16'hAAAA mid-frame, then 16'h0F0F two cycles later → the current frame is unchanged, the next frame shows 0F0F, and `update_pending` is high until the frame boundary.
- **Load at frame end:** `load` exactly at `cnt`=7, `idx`=3 with 16'h8888 → 8888 is displayed next frame and `update_pending` never rises.
- **Blanking:** `blank`=0101 → `an[0]` and `an[2]` stay 1 all frame, and segments are all 1 during those slots.
- **Reset mid-frame:** assert `rst` in slot 2 with an update pending → next cycle all outputs are at reset values, `update_pending`=0, and the display stays dark.
